// File: rtl/hdlc_protocol_monitor_if.sv
// Signal bundle between an HDLC core (line plus status strobes) and its protocol monitor.
// CNT_W must match the CNT_W of the monitor attached to the slave side.
interface hdlc_protocol_monitor_if #(
  parameter int CNT_W = 16
);
  logic             Enable;
  logic             ClrErr;
  logic             Line;
  logic             FlagDetect;
  logic             AbortSignal;
  logic             EoF;
  logic             ValidFrame;
  logic             NewByte;
  logic             Overflow;
  logic             ErrFlag;
  logic [2:0]       ErrCode;
  logic [5:0]       ErrVec;
  logic [CNT_W-1:0] ErrCnt;
  logic [CNT_W-1:0] FrameCnt;
  logic [1:0]       LineState;

  modport master (
    output Enable, ClrErr, Line, FlagDetect, AbortSignal, EoF, ValidFrame, NewByte, Overflow,
    input  ErrFlag, ErrCode, ErrVec, ErrCnt, FrameCnt, LineState
  );

  modport slave (
    input  Enable, ClrErr, Line, FlagDetect, AbortSignal, EoF, ValidFrame, NewByte, Overflow,
    output ErrFlag, ErrCode, ErrVec, ErrCnt, FrameCnt, LineState
  );
endinterface

// File: rtl/hdlc_protocol_monitor.sv
// HDLC protocol monitor: tracks line state from flag/abort/idle patterns and checks the
// core's status strobes against them, with sticky error capture and saturating counters.
module hdlc_protocol_monitor #(
  parameter int         FLAG_LATENCY  = 2,
  parameter int         ABORT_LATENCY = 1,
  parameter int         MAX_BYTES     = 128,
  parameter int         CNT_W         = 16,
  parameter logic [5:0] CHECK_MASK    = 6'b111111
) (
  input logic                    Clk,
  input logic                    Rst,
  hdlc_protocol_monitor_if.slave mon
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OPEN    = 2'd1;
  localparam logic [1:0] ABORTED = 2'd2;

  localparam int             BC_W       = $clog2(MAX_BYTES + 2);
  localparam logic [BC_W-1:0] BYTE_LAST  = BC_W'(MAX_BYTES);
  localparam logic [BC_W-1:0] BYTE_LIMIT = BC_W'(MAX_BYTES + 1);

  // Only the seven newest history bits are ever needed to form the 8-bit window.
  logic [6:0]               sr;
  logic [7:0]               window;
  logic                     flagHit;
  logic                     abortHit;
  logic                     idleHit;
  logic [1:0]               lineState;
  logic [FLAG_LATENCY-1:0]  flagPipe;
  logic [ABORT_LATENCY-1:0] abortPipe;
  logic                     eofPipe;
  logic                     ovfPipe;
  logic                     vfPrev;
  logic                     ovfPrev;
  logic [BC_W-1:0]          byteCnt;
  logic                     vfRise;
  logic                     vfFall;
  logic                     byteIn;
  logic                     byteReach;
  logic [5:0]               rawFail;
  logic [5:0]               fails;
  logic                     anyFail;
  logic [2:0]               lowIdx;
  logic                     errFlag;
  logic [2:0]               errCode;
  logic [5:0]               errVec;
  logic [CNT_W-1:0]         errCnt;
  logic [CNT_W-1:0]         frameCnt;

  assign window    = {sr, mon.Line};
  assign flagHit   = (window == 8'h7E);
  assign abortHit  = (window == 8'h7F);
  assign idleHit   = (window == 8'hFF);
  assign vfRise    = mon.ValidFrame & ~vfPrev;
  assign vfFall    = ~mon.ValidFrame & vfPrev;
  assign byteIn    = mon.NewByte & mon.ValidFrame;
  // A rising ValidFrame restarts the count, so a byte on that cycle cannot hit the limit.
  assign byteReach = byteIn & ~vfRise & (byteCnt == BYTE_LAST);

  always_comb begin
    rawFail    = '0;
    rawFail[0] = flagPipe[FLAG_LATENCY-1] & ~mon.FlagDetect;
    rawFail[1] = mon.FlagDetect & ~flagPipe[FLAG_LATENCY-1];
    rawFail[2] = abortPipe[ABORT_LATENCY-1] & ~mon.AbortSignal;
    rawFail[3] = eofPipe & ~mon.EoF;
    rawFail[4] = ovfPipe & ~mon.Overflow;
    rawFail[5] = mon.Overflow & ~ovfPrev & (byteCnt <= BYTE_LAST);
    fails      = mon.Enable ? (rawFail & CHECK_MASK) : 6'b000000;
    anyFail    = |fails;
  end

  always_comb begin
    lowIdx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (fails[i]) lowIdx = 3'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sr        <= 7'h7F;
      lineState <= IDLE;
      flagPipe  <= '0;
      abortPipe <= '0;
      eofPipe   <= 1'b0;
      ovfPipe   <= 1'b0;
      vfPrev    <= 1'b0;
      ovfPrev   <= 1'b0;
      byteCnt   <= '0;
      frameCnt  <= '0;
    end else if (mon.Enable) begin
      sr        <= window[6:0];
      flagPipe  <= FLAG_LATENCY'({flagPipe, flagHit});
      abortPipe <= ABORT_LATENCY'({abortPipe, abortHit & mon.ValidFrame});
      eofPipe   <= vfFall;
      ovfPipe   <= byteReach;
      vfPrev    <= mon.ValidFrame;
      ovfPrev   <= mon.Overflow;
      if (vfRise) begin
        byteCnt <= '0;
      end else if (byteIn && byteCnt != BYTE_LIMIT) begin
        byteCnt <= byteCnt + 1'b1;
      end
      if (mon.EoF && frameCnt != '1) frameCnt <= frameCnt + 1'b1;
      case (lineState)
        IDLE:    if (flagHit) lineState <= OPEN;
        OPEN: begin
          if (abortHit)     lineState <= ABORTED;
          else if (idleHit) lineState <= IDLE;
        end
        ABORTED: begin
          if (flagHit)      lineState <= OPEN;
          else if (idleHit) lineState <= IDLE;
        end
        default:            lineState <= IDLE;
      endcase
    end
  end

  // The clear drops old sticky bits but a failure in the same cycle still lands.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      errFlag <= 1'b0;
      errCode <= 3'd0;
      errVec  <= 6'b000000;
      errCnt  <= '0;
    end else begin
      errFlag <= anyFail;
      if (anyFail) errCode <= lowIdx;
      errVec <= (mon.ClrErr ? 6'b000000 : errVec) | fails;
      if (mon.ClrErr) begin
        errCnt <= {{(CNT_W-1){1'b0}}, anyFail};
      end else if (anyFail && errCnt != '1) begin
        errCnt <= errCnt + 1'b1;
      end
    end
  end

  assign mon.ErrFlag   = errFlag;
  assign mon.ErrCode   = errCode;
  assign mon.ErrVec    = errVec;
  assign mon.ErrCnt    = errCnt;
  assign mon.FrameCnt  = frameCnt;
  assign mon.LineState = lineState;

endmodule

// File: tb/tb_hdlc_protocol_monitor.sv
// Bench for hdlc_protocol_monitor: directed table and sequences, then random traffic
// checked every cycle against a history-based reference model.
module tb_hdlc_protocol_monitor;

  localparam int FL   = 2;
  localparam int AL   = 1;
  localparam int MAXB = 128;
  localparam int HMAX = 8192;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic enable = 1'b1, clrErr = 1'b0, lineBit = 1'b1, flagDet = 1'b0, abortSig = 1'b0;
  logic eofIn = 1'b0, validFrame = 1'b0, newByte = 1'b0, overflow = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  hdlc_protocol_monitor_if #(.CNT_W(16)) busF ();
  hdlc_protocol_monitor_if #(.CNT_W(4))  busM ();

  assign busF.Enable = enable;       assign busM.Enable = enable;
  assign busF.ClrErr = clrErr;       assign busM.ClrErr = clrErr;
  assign busF.Line = lineBit;        assign busM.Line = lineBit;
  assign busF.FlagDetect = flagDet;  assign busM.FlagDetect = flagDet;
  assign busF.AbortSignal = abortSig; assign busM.AbortSignal = abortSig;
  assign busF.EoF = eofIn;           assign busM.EoF = eofIn;
  assign busF.ValidFrame = validFrame; assign busM.ValidFrame = validFrame;
  assign busF.NewByte = newByte;     assign busM.NewByte = newByte;
  assign busF.Overflow = overflow;   assign busM.Overflow = overflow;

  hdlc_protocol_monitor #(.FLAG_LATENCY(FL), .ABORT_LATENCY(AL), .MAX_BYTES(MAXB),
                          .CNT_W(16), .CHECK_MASK(6'b111111))
    dut (.Clk(Clk), .Rst(Rst), .mon(busF));

  hdlc_protocol_monitor #(.FLAG_LATENCY(FL), .ABORT_LATENCY(AL), .MAX_BYTES(MAXB),
                          .CNT_W(4), .CHECK_MASK(6'b011111))
    dutM (.Clk(Clk), .Rst(Rst), .mon(busM));

  // Reference model: per-tick input history since the last reset, checks derived by looking back.
  bit hLine[HMAX], hFd[HMAX], hAb[HMAX], hVf[HMAX], hNb[HMAX], hOvf[HMAX], hEof[HMAX];
  int tk = 0;
  int base = 0;
  int eState = 0;
  int eFlag[2], eCode[2], eVec[2], eCnt[2], eFc[2];
  int cntMax[2] = '{65535, 15};
  bit [5:0] maskOf[2] = '{6'b111111, 6'b011111};

  function automatic bit bitAt(int j);
    if (j < base) return 1'b1;
    return hLine[j];
  endfunction

  function automatic bit [7:0] winAt(int k);
    bit [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = bitAt(k - i);
    return w;
  endfunction

  function automatic bit isFlag(int k);  return (k >= base) && (winAt(k) == 8'h7E); endfunction
  function automatic bit isAbort(int k); return (k >= base) && (winAt(k) == 8'h7F); endfunction
  function automatic bit isIdle(int k);  return (k >= base) && (winAt(k) == 8'hFF); endfunction
  function automatic bit vfAt(int j);    return (j >= base) && hVf[j]; endfunction
  function automatic bit ovfAt(int j);   return (j >= base) && hOvf[j]; endfunction
  function automatic bit riseAt(int j);  return vfAt(j) && !vfAt(j - 1); endfunction

  function automatic int bytesBefore(int k);
    int r = -1;
    int n = 0;
    for (int j = k - 1; j >= base; j--) begin
      if (riseAt(j)) begin r = j; break; end
    end
    if (r < 0) return 0;
    for (int j = r + 1; j < k; j++) begin
      if (hNb[j] && hVf[j] && n < MAXB + 1) n++;
    end
    return n;
  endfunction

  function automatic bit reachAt(int j);
    return (j >= base) && hNb[j] && hVf[j] && !riseAt(j) && (bytesBefore(j) == MAXB);
  endfunction

  function automatic bit [5:0] rawAt(int k);
    bit [5:0] f;
    bit fexp, aexp;
    fexp = isFlag(k - FL);
    aexp = isAbort(k - AL) && hVf[k - AL];
    f[0] = fexp && !hFd[k];
    f[1] = hFd[k] && !fexp;
    f[2] = aexp && !hAb[k];
    f[3] = (k - 1 >= base) && !hVf[k - 1] && vfAt(k - 2) && !hEof[k];
    f[4] = (k - 1 >= base) && reachAt(k - 1) && !hOvf[k];
    f[5] = hOvf[k] && !ovfAt(k - 1) && (bytesBefore(k) <= MAXB);
    return f;
  endfunction

  task automatic modelEdge();
    bit [5:0] raw, m;
    if (Rst) begin
      base = tk;
      eState = 0;
      for (int d = 0; d < 2; d++) begin
        eFlag[d] = 0; eCode[d] = 0; eVec[d] = 0; eCnt[d] = 0; eFc[d] = 0;
      end
      return;
    end
    if (!enable) begin
      for (int d = 0; d < 2; d++) begin
        eFlag[d] = 0;
        if (clrErr) begin eVec[d] = 0; eCnt[d] = 0; end
      end
      return;
    end
    hLine[tk] = lineBit; hFd[tk] = flagDet; hAb[tk] = abortSig; hVf[tk] = validFrame;
    hNb[tk] = newByte; hOvf[tk] = overflow; hEof[tk] = eofIn;
    raw = rawAt(tk);
    if (isFlag(tk)) eState = 1;
    else if (isIdle(tk)) eState = 0;
    else if (isAbort(tk) && eState == 1) eState = 2;
    for (int d = 0; d < 2; d++) begin
      m = raw & maskOf[d];
      eFlag[d] = (m != 0) ? 1 : 0;
      for (int i = 5; i >= 0; i--) if (m[i]) eCode[d] = i;
      eVec[d] = (clrErr ? 0 : eVec[d]) | int'(m);
      if (clrErr) eCnt[d] = (m != 0) ? 1 : 0;
      else if (m != 0 && eCnt[d] < cntMax[d]) eCnt[d]++;
      if (eofIn && eFc[d] < cntMax[d]) eFc[d]++;
    end
    tk++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("F.ErrFlag", 32'(busF.ErrFlag), eFlag[0]);
    check("F.ErrCode", 32'(busF.ErrCode), eCode[0]);
    check("F.ErrVec", 32'(busF.ErrVec), eVec[0]);
    check("F.ErrCnt", 32'(busF.ErrCnt), eCnt[0]);
    check("F.FrameCnt", 32'(busF.FrameCnt), eFc[0]);
    check("F.LineState", 32'(busF.LineState), eState);
    check("M.ErrFlag", 32'(busM.ErrFlag), eFlag[1]);
    check("M.ErrCode", 32'(busM.ErrCode), eCode[1]);
    check("M.ErrVec", 32'(busM.ErrVec), eVec[1]);
    check("M.ErrCnt", 32'(busM.ErrCnt), eCnt[1]);
    check("M.FrameCnt", 32'(busM.FrameCnt), eFc[1]);
    check("M.LineState", 32'(busM.LineState), eState);
  endtask

  task automatic step();
    @(posedge Clk);
    modelEdge();
    @(negedge Clk);
    checkOutput();
  endtask

  task automatic sendBits(input bit [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      lineBit = b[i];
      step();
    end
  endtask

  typedef struct {
    bit line;
    bit fd;
    bit ab;
    bit vf;
    int st;
    bit flg;
    int code;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit l, input bit f, input int st, input bit flg, input int code);
    vecs.push_back('{l, f, 1'b0, 1'b0, st, flg, code});
  endtask

  task automatic applyStimulus(input vec_t v);
    lineBit = v.line; flagDet = v.fd; abortSig = v.ab; validFrame = v.vf;
  endtask

  initial begin
    bit [7:0] pat;
    bit injQ[$];
    int k;

    // Flag timing table: idle line, on-time FlagDetect, then one delivered a cycle late.
    for (int i = 0; i < 20; i++) addVec(1, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) addVec(1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0);
    addVec(0, 0, 1, 0, 0);
    addVec(0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 0);
    addVec(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) addVec(1, 0, 1, 0, 0);
    addVec(0, 0, 1, 0, 0);
    addVec(0, 0, 1, 0, 0);
    addVec(0, 0, 1, 1, 0);
    addVec(0, 1, 1, 1, 1);
    addVec(0, 0, 1, 0, 0);

    step();
    step();
    check("rst.LineState", 32'(busF.LineState), 0);
    check("rst.ErrFlag", 32'(busF.ErrFlag), 0);
    check("rst.ErrCode", 32'(busF.ErrCode), 0);
    check("rst.ErrVec", 32'(busF.ErrVec), 0);
    check("rst.ErrCnt", 32'(busF.ErrCnt), 0);
    check("rst.FrameCnt", 32'(busF.FrameCnt), 0);
    Rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      step();
      check("tbl.LineState", 32'(busF.LineState), vecs[i].st);
      check("tbl.ErrFlag", 32'(busF.ErrFlag), 32'(vecs[i].flg));
      if (vecs[i].flg) check("tbl.ErrCode", 32'(busF.ErrCode), vecs[i].code);
    end
    check("flag.ErrVec", 32'(busF.ErrVec), 6'b000011);
    check("flag.ErrCnt", 32'(busF.ErrCnt), 2);

    // Abort inside a frame with AbortSignal missing, then delivered on time.
    validFrame = 1'b1; lineBit = 1'b0;
    step();
    sendBits(8'h7F);
    check("abort.LineState", 32'(busF.LineState), 2);
    lineBit = 1'b0;
    step();
    check("abort.ErrFlag", 32'(busF.ErrFlag), 1);
    check("abort.ErrCode", 32'(busF.ErrCode), 2);
    check("abort.ErrVec", 32'(busF.ErrVec), 6'b000111);
    step();
    step();
    sendBits(8'h7F);
    abortSig = 1'b1; lineBit = 1'b0;
    step();
    check("abortOk.ErrFlag", 32'(busF.ErrFlag), 0);
    abortSig = 1'b0;
    step();

    // End of frame with and without EoF.
    check("eof.FrameCnt0", 32'(busF.FrameCnt), 0);
    validFrame = 1'b0;
    step();
    eofIn = 1'b1;
    step();
    check("eof.ErrFlag", 32'(busF.ErrFlag), 0);
    check("eof.FrameCnt1", 32'(busF.FrameCnt), 1);
    eofIn = 1'b0;
    validFrame = 1'b1;
    step();
    step();
    validFrame = 1'b0;
    step();
    step();
    check("eofMiss.ErrFlag", 32'(busF.ErrFlag), 1);
    check("eofMiss.ErrCode", 32'(busF.ErrCode), 3);

    // 129 bytes with Overflow right after the last one, then an early Overflow.
    validFrame = 1'b1;
    step();
    newByte = 1'b1;
    for (int i = 0; i < MAXB + 1; i++) step();
    newByte = 1'b0; overflow = 1'b1;
    step();
    check("ovf.ErrFlag", 32'(busF.ErrFlag), 0);
    overflow = 1'b0;
    step();
    check("ovf.after", 32'(busF.ErrFlag), 0);
    validFrame = 1'b0;
    step();
    eofIn = 1'b1;
    step();
    eofIn = 1'b0; validFrame = 1'b1;
    step();
    newByte = 1'b1;
    for (int i = 0; i < 50; i++) step();
    newByte = 1'b0; overflow = 1'b1;
    step();
    check("ovfSpur.ErrFlag", 32'(busF.ErrFlag), 1);
    check("ovfSpur.ErrCode", 32'(busF.ErrCode), 5);
    check("ovfSpurMasked.ErrFlag", 32'(busM.ErrFlag), 0);
    check("ovfSpurMasked.bit5", 32'(busM.ErrVec[5]), 0);
    overflow = 1'b0;
    step();

    // FLAG_MISS and EOF_MISS landing on the same cycle, then ClrErr.
    clrErr = 1'b1;
    step();
    clrErr = 1'b0;
    check("clr.ErrVec", 32'(busF.ErrVec), 0);
    check("clr.ErrCnt", 32'(busF.ErrCnt), 0);
    sendBits(8'h7E);
    lineBit = 1'b0; validFrame = 1'b0;
    step();
    step();
    check("dual.ErrFlag", 32'(busF.ErrFlag), 1);
    check("dual.ErrCode", 32'(busF.ErrCode), 0);
    check("dual.ErrVec", 32'(busF.ErrVec), 6'b001001);
    check("dual.ErrCnt", 32'(busF.ErrCnt), 1);
    clrErr = 1'b1;
    step();
    clrErr = 1'b0;
    check("clr2.ErrVec", 32'(busF.ErrVec), 0);
    check("clr2.ErrCnt", 32'(busF.ErrCnt), 0);

    // Reset while a flag expectation is pending must not leave a late error behind.
    validFrame = 1'b1;
    step();
    sendBits(8'h7E);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstMid.ErrFlag", 32'(busF.ErrFlag), 0);
    end
    check("rstMid.ErrVec", 32'(busF.ErrVec), 0);
    check("rstMid.LineState", 32'(busF.LineState), 0);

    // Random traffic: mostly well-behaved strobes with occasional faults, resets and stalls.
    for (int c = 0; c < 4000; c++) begin
      k = tk;
      Rst    = ($urandom_range(0, 599) == 0);
      enable = ($urandom_range(0, 19) != 0);
      clrErr = ($urandom_range(0, 39) == 0);
      if (injQ.size() == 0 && $urandom_range(0, 11) == 0) begin
        pat = ($urandom_range(0, 2) == 0) ? 8'h7F : 8'h7E;
        for (int i = 7; i >= 0; i--) injQ.push_back(pat[i]);
      end
      if (injQ.size() != 0) lineBit = injQ.pop_front();
      else lineBit = ($urandom_range(0, 3) != 0);
      flagDet  = isFlag(k - FL) ^ ($urandom_range(0, 15) == 0);
      abortSig = (isAbort(k - AL) && vfAt(k - AL)) ^ ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 249) == 0) validFrame = !validFrame;
      if (!vfAt(k - 1) && vfAt(k - 2)) eofIn = ($urandom_range(0, 7) != 0);
      else eofIn = ($urandom_range(0, 63) == 0);
      newByte  = validFrame && ($urandom_range(0, 1) == 1);
      if (reachAt(k - 1)) overflow = ($urandom_range(0, 7) != 0);
      else overflow = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
